// File: rtl/mul_share_sequencer.sv
// Two-port 32x32 unsigned multiply sequencer built on one shared 16x16 multiplier.
// Each accepted request issues four partial products and accumulates them as they return.
module mul_share_sequencer #(
  parameter int MUL_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req_valid,
  output logic        p0_req_ready,
  input  logic [31:0] p0_src1,
  input  logic [31:0] p0_src2,
  output logic        p0_resp_valid,
  input  logic        p0_resp_ready,
  output logic [63:0] p0_resp_data,
  input  logic        p1_req_valid,
  output logic        p1_req_ready,
  input  logic [31:0] p1_src1,
  input  logic [31:0] p1_src2,
  output logic        p1_resp_valid,
  input  logic        p1_resp_ready,
  output logic [63:0] p1_resp_data,
  output logic [15:0] mul_a,
  output logic [15:0] mul_b,
  output logic        mul_en,
  input  logic [31:0] mul_p,
  output logic        busy,
  output logic        grant_id
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

  state_t       state_reg, state_next;
  logic [1:0]   k_reg, k_next;
  logic [2:0]   drain_reg, drain_next;
  logic [31:0]  a_reg, b_reg;
  logic [63:0]  acc_reg;
  logic         grant_reg, last_grant_reg;
  logic         win, accept, resp_fire;
  logic [63:0]  addend;

  // {valid, k} travelling alongside the external multiplier pipeline
  logic [MUL_LAT-1:0] sr_valid;
  logic [1:0]         sr_k [MUL_LAT];

  always_comb begin
    win = 1'b0;
    if (p0_req_valid && p1_req_valid) begin
      win = ~last_grant_reg;
    end else if (p1_req_valid) begin
      win = 1'b1;
    end
  end

  always_comb begin
    state_next    = state_reg;
    k_next        = k_reg;
    drain_next    = drain_reg;
    accept        = 1'b0;
    resp_fire     = 1'b0;
    p0_req_ready  = 1'b0;
    p1_req_ready  = 1'b0;
    p0_resp_valid = 1'b0;
    p1_resp_valid = 1'b0;
    mul_en        = 1'b0;
    mul_a         = 16'd0;
    mul_b         = 16'd0;
    case (state_reg)
      IDLE: begin
        if (p0_req_valid || p1_req_valid) begin
          accept       = 1'b1;
          p0_req_ready = ~win;
          p1_req_ready = win;
          k_next       = 2'd0;
          state_next   = ISSUE;
        end
      end
      ISSUE: begin
        mul_en = 1'b1;
        case (k_reg)
          2'd0: begin mul_a = a_reg[15:0];  mul_b = b_reg[15:0];  end
          2'd1: begin mul_a = a_reg[31:16]; mul_b = b_reg[15:0];  end
          2'd2: begin mul_a = a_reg[15:0];  mul_b = b_reg[31:16]; end
          default: begin mul_a = a_reg[31:16]; mul_b = b_reg[31:16]; end
        endcase
        k_next = k_reg + 2'd1;
        if (k_reg == 2'd3) begin
          drain_next = 3'd0;
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        // wait for the last partial product to come back and be summed
        drain_next = drain_reg + 3'd1;
        if (drain_reg == 3'(MUL_LAT - 1)) begin
          state_next = RESP;
        end
      end
      RESP: begin
        p0_resp_valid = ~grant_reg;
        p1_resp_valid = grant_reg;
        resp_fire     = grant_reg ? p1_resp_ready : p0_resp_ready;
        if (resp_fire) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    addend = 64'd0;
    case (sr_k[MUL_LAT-1])
      2'd0:       addend = {32'd0, mul_p};
      2'd1, 2'd2: addend = {16'd0, mul_p, 16'd0};
      default:    addend = {mul_p, 32'd0};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      k_reg          <= 2'd0;
      drain_reg      <= 3'd0;
      acc_reg        <= 64'd0;
      a_reg          <= 32'd0;
      b_reg          <= 32'd0;
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
      drain_reg <= drain_next;
      if (accept) begin
        a_reg          <= win ? p1_src1 : p0_src1;
        b_reg          <= win ? p1_src2 : p0_src2;
        grant_reg      <= win;
        last_grant_reg <= win;
        acc_reg        <= 64'd0;
      end else if (sr_valid[MUL_LAT-1]) begin
        acc_reg <= acc_reg + addend;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MUL_LAT; i++) begin
        sr_valid[i] <= 1'b0;
        sr_k[i]     <= 2'd0;
      end
    end else begin
      sr_valid[0] <= mul_en;
      sr_k[0]     <= k_reg;
      for (int i = 1; i < MUL_LAT; i++) begin
        sr_valid[i] <= sr_valid[i-1];
        sr_k[i]     <= sr_k[i-1];
      end
    end
  end

  assign p0_resp_data = acc_reg;
  assign p1_resp_data = acc_reg;
  assign busy         = (state_reg != IDLE);
  assign grant_id     = grant_reg;

endmodule

// File: tb/tb_mul_share_sequencer.sv
// Directed bench: one sequencer with a 1-cycle multiplier model, one with a 3-cycle model.
module tb_mul_share_sequencer;

  logic clk;
  logic reset;

  logic        p0_req_valid, p0_req_ready, p0_resp_valid, p0_resp_ready;
  logic [31:0] p0_src1, p0_src2;
  logic [63:0] p0_resp_data;
  logic        p1_req_valid, p1_req_ready, p1_resp_valid, p1_resp_ready;
  logic [31:0] p1_src1, p1_src2;
  logic [63:0] p1_resp_data;
  logic [15:0] mul_a, mul_b;
  logic        mul_en;
  logic [31:0] mul_p;
  logic        busy, grant_id;

  logic        d3_p0_req_valid, d3_p0_req_ready, d3_p0_resp_valid, d3_p0_resp_ready;
  logic [31:0] d3_p0_src1, d3_p0_src2;
  logic [63:0] d3_p0_resp_data;
  logic        d3_p1_req_valid, d3_p1_req_ready, d3_p1_resp_valid, d3_p1_resp_ready;
  logic [31:0] d3_p1_src1, d3_p1_src2;
  logic [63:0] d3_p1_resp_data;
  logic [15:0] d3_mul_a, d3_mul_b;
  logic        d3_mul_en;
  logic [31:0] d3_mul_p;
  logic        d3_busy, d3_grant_id;
  logic [31:0] d3_pipe [3];

  int checks;
  int failures;

  mul_share_sequencer #(.MUL_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready),
    .p0_src1(p0_src1), .p0_src2(p0_src2),
    .p0_resp_valid(p0_resp_valid), .p0_resp_ready(p0_resp_ready), .p0_resp_data(p0_resp_data),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready),
    .p1_src1(p1_src1), .p1_src2(p1_src2),
    .p1_resp_valid(p1_resp_valid), .p1_resp_ready(p1_resp_ready), .p1_resp_data(p1_resp_data),
    .mul_a(mul_a), .mul_b(mul_b), .mul_en(mul_en), .mul_p(mul_p),
    .busy(busy), .grant_id(grant_id)
  );

  mul_share_sequencer #(.MUL_LAT(3)) dut3 (
    .clk(clk), .reset(reset),
    .p0_req_valid(d3_p0_req_valid), .p0_req_ready(d3_p0_req_ready),
    .p0_src1(d3_p0_src1), .p0_src2(d3_p0_src2),
    .p0_resp_valid(d3_p0_resp_valid), .p0_resp_ready(d3_p0_resp_ready), .p0_resp_data(d3_p0_resp_data),
    .p1_req_valid(d3_p1_req_valid), .p1_req_ready(d3_p1_req_ready),
    .p1_src1(d3_p1_src1), .p1_src2(d3_p1_src2),
    .p1_resp_valid(d3_p1_resp_valid), .p1_resp_ready(d3_p1_resp_ready), .p1_resp_data(d3_p1_resp_data),
    .mul_a(d3_mul_a), .mul_b(d3_mul_b), .mul_en(d3_mul_en), .mul_p(d3_mul_p),
    .busy(d3_busy), .grant_id(d3_grant_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // External multiplier models: registered 16x16 products, 1 and 3 cycles deep
  always @(posedge clk) begin
    mul_p      <= {16'd0, mul_a} * {16'd0, mul_b};
    d3_pipe[0] <= {16'd0, d3_mul_a} * {16'd0, d3_mul_b};
    d3_pipe[1] <= d3_pipe[0];
    d3_pipe[2] <= d3_pipe[1];
  end
  assign d3_mul_p = d3_pipe[2];

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Drives one request on a port of the MUL_LAT=1 instance and reports what was observed.
  // lat is counted in cycles from the accept cycle; -1 means no accept or no response.
  task automatic run_txn(input bit port, input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] data, output int lat, output int en_first,
                         output int en_cnt, output bit wrong_port);
    bit ready_seen;
    data = '0; lat = -1; en_first = -1; en_cnt = 0; wrong_port = 1'b0; ready_seen = 1'b0;
    @(posedge clk); #1;
    if (port) begin
      p1_req_valid = 1'b1; p1_src1 = a; p1_src2 = b; p1_resp_ready = 1'b1;
    end else begin
      p0_req_valid = 1'b1; p0_src1 = a; p0_src2 = b; p0_resp_ready = 1'b1;
    end
    for (int c = 0; c < 40 && !ready_seen; c++) begin
      @(negedge clk);
      ready_seen = port ? p1_req_ready : p0_req_ready;
    end
    @(posedge clk); #1;
    p0_req_valid = 1'b0; p1_req_valid = 1'b0;
    p0_src1 = 32'hDEAD_BEEF; p0_src2 = 32'hCAFE_F00D;
    p1_src1 = 32'h5A5A_A5A5; p1_src2 = 32'h1357_9BDF;
    if (ready_seen) begin
      for (int c = 1; c <= 40; c++) begin
        @(negedge clk);
        if (mul_en) begin
          en_cnt++;
          if (en_first < 0) en_first = c;
        end
        if (port ? p0_resp_valid : p1_resp_valid) wrong_port = 1'b1;
        if (port ? p1_resp_valid : p0_resp_valid) begin
          lat  = c;
          data = port ? p1_resp_data : p0_resp_data;
          break;
        end
      end
      @(posedge clk); #1;
    end
    p0_resp_ready = 1'b0; p1_resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (mul_en !== 1'b0 || mul_a !== 16'd0 || mul_b !== 16'd0) begin
      failures++; $display("FAIL reset_mul got en=%b a=%h b=%h exp en=0 a=0 b=0", mul_en, mul_a, mul_b); end
    checks++; if (p0_resp_valid !== 1'b0 || p1_resp_valid !== 1'b0) begin
      failures++; $display("FAIL reset_resp_valid got=%b%b exp=00", p0_resp_valid, p1_resp_valid); end
    checks++; if (p0_resp_data !== 64'd0 || p1_resp_data !== 64'd0) begin
      failures++; $display("FAIL reset_resp_data got=%h exp=0", p0_resp_data); end
    checks++; if (grant_id !== 1'b0) begin failures++; $display("FAIL reset_grant_id got=%b exp=0", grant_id); end
    checks++; if (d3_busy !== 1'b0) begin failures++; $display("FAIL reset_busy_lat3 got=%b exp=0", d3_busy); end
    p0_req_valid = 1'b1; p1_req_valid = 1'b1;
    #1;
    checks++; if (p0_req_ready !== 1'b1 || p1_req_ready !== 1'b0) begin
      failures++; $display("FAIL reset_tie_ready got p0=%b p1=%b exp p0=1 p1=0", p0_req_ready, p1_req_ready); end
    p0_req_valid = 1'b0;
    #1;
    checks++; if (p1_req_ready !== 1'b1 || p0_req_ready !== 1'b0) begin
      failures++; $display("FAIL reset_single_ready got p0=%b p1=%b exp p0=0 p1=1", p0_req_ready, p1_req_ready); end
    p1_req_valid = 1'b0;
    #1;
    checks++; if (p1_req_ready !== 1'b0 || p0_req_ready !== 1'b0) begin
      failures++; $display("FAIL reset_no_req_ready got p0=%b p1=%b exp 0 0", p0_req_ready, p1_req_ready); end
  endtask

  task automatic test_basic();
    logic [63:0] d; int lat, ef, ec; bit wp;
    run_txn(1'b0, 32'h0001_0002, 32'h0003_0004, d, lat, ef, ec, wp);
    checks++; if (d !== 64'h0000_0003_000A_0008) begin failures++; $display("FAIL basic_data got=%h exp=00000003000a0008", d); end
    checks++; if (lat !== 6) begin failures++; $display("FAIL basic_latency got=%0d exp=6", lat); end
    checks++; if (ef !== 1 || ec !== 4) begin failures++; $display("FAIL basic_mul_en got first=%0d cnt=%0d exp first=1 cnt=4", ef, ec); end
    checks++; if (wp !== 1'b0) begin failures++; $display("FAIL basic_other_port got=%b exp=0", wp); end
  endtask

  task automatic test_edges();
    logic [31:0] av [5];
    logic [31:0] bv [5];
    logic [63:0] ev [5];
    bit          pv [5];
    logic [63:0] d; int lat, ef, ec; bit wp;
    av[0] = 32'hFFFF_FFFF; bv[0] = 32'hFFFF_FFFF; ev[0] = 64'hFFFF_FFFE_0000_0001; pv[0] = 1'b0;
    av[1] = 32'h0000_0000; bv[1] = 32'h1234_5678; ev[1] = 64'h0;                   pv[1] = 1'b0;
    av[2] = 32'hFFFF_0000; bv[2] = 32'h0000_FFFF; ev[2] = 64'h0000_FFFE_0001_0000; pv[2] = 1'b1;
    av[3] = 32'h0000_FFFF; bv[3] = 32'hFFFF_0000; ev[3] = 64'h0000_FFFE_0001_0000; pv[3] = 1'b0;
    av[4] = 32'h0003_0000; bv[4] = 32'h0000_0005; ev[4] = 64'h0000_0000_000F_0000; pv[4] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      run_txn(pv[i], av[i], bv[i], d, lat, ef, ec, wp);
      $display("edge txn %0d port=%0d a=%h b=%h data=%h lat=%0d", i, pv[i], av[i], bv[i], d, lat);
      checks++; if (d !== ev[i] || lat !== 6 || wp !== 1'b0) begin
        failures++; $display("FAIL edge_%0d got data=%h lat=%0d other=%b exp data=%h lat=6 other=0", i, d, lat, wp, ev[i]); end
      checks++; if (grant_id !== pv[i]) begin failures++; $display("FAIL edge_grant_%0d got=%b exp=%b", i, grant_id, pv[i]); end
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] a0 [2], b0 [2], a1 [2], b1 [2];
    logic [63:0] e0 [2], e1 [2];
    int i0, i1, r0, r1, nacc;
    bit acc0, acc1;
    a0[0] = 32'h0000_0005; b0[0] = 32'h0000_0007; e0[0] = 64'h23;
    a0[1] = 32'h0001_0000; b0[1] = 32'h0001_0000; e0[1] = 64'h1_0000_0000;
    a1[0] = 32'h0000_FFFF; b1[0] = 32'h0000_0002; e1[0] = 64'h1FFFE;
    a1[1] = 32'h0002_0000; b1[1] = 32'h0000_0003; e1[1] = 64'h6_0000;
    i0 = 0; i1 = 0; r0 = 0; r1 = 0; nacc = 0;
    apply_reset();
    p0_req_valid = 1'b1; p0_src1 = a0[0]; p0_src2 = b0[0]; p0_resp_ready = 1'b1;
    p1_req_valid = 1'b1; p1_src1 = a1[0]; p1_src2 = b1[0]; p1_resp_ready = 1'b1;
    for (int c = 0; c < 200 && (r0 + r1) < 4; c++) begin
      @(negedge clk);
      acc0 = p0_req_ready; acc1 = p1_req_ready;
      if (acc0 || acc1) begin
        $display("rr accept %0d port=%0d", nacc, acc1);
        checks++; if (acc1 !== (nacc % 2 == 1) || acc0 === acc1) begin
          failures++; $display("FAIL rr_grant_order_%0d got p0=%b p1=%b exp port=%0d", nacc, acc0, acc1, nacc % 2); end
        nacc++;
      end
      if (p0_resp_valid) begin
        checks++; if (r0 > 1 || p0_resp_data !== e0[r0 % 2] || p1_resp_valid !== 1'b0 || grant_id !== 1'b0) begin
          failures++; $display("FAIL rr_p0_resp_%0d got=%h other=%b gid=%b exp=%h", r0, p0_resp_data, p1_resp_valid, grant_id, e0[r0 % 2]); end
        r0++;
      end
      if (p1_resp_valid) begin
        checks++; if (r1 > 1 || p1_resp_data !== e1[r1 % 2] || p0_resp_valid !== 1'b0 || grant_id !== 1'b1) begin
          failures++; $display("FAIL rr_p1_resp_%0d got=%h other=%b gid=%b exp=%h", r1, p1_resp_data, p0_resp_valid, grant_id, e1[r1 % 2]); end
        r1++;
      end
      @(posedge clk); #1;
      if (acc0) begin
        i0++;
        if (i0 < 2) begin p0_src1 = a0[i0]; p0_src2 = b0[i0]; end else p0_req_valid = 1'b0;
      end
      if (acc1) begin
        i1++;
        if (i1 < 2) begin p1_src1 = a1[i1]; p1_src2 = b1[i1]; end else p1_req_valid = 1'b0;
      end
    end
    checks++; if (r0 !== 2 || r1 !== 2 || nacc !== 4) begin
      failures++; $display("FAIL rr_counts got r0=%0d r1=%0d acc=%0d exp 2 2 4", r0, r1, nacc); end
    p0_req_valid = 1'b0; p1_req_valid = 1'b0; p0_resp_ready = 1'b0; p1_resp_ready = 1'b0;
  endtask

  task automatic test_resp_hold();
    bit seen;
    seen = 1'b0;
    @(posedge clk); #1;
    p1_req_valid = 1'b1; p1_src1 = 32'h100; p1_src2 = 32'h100; p1_resp_ready = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin @(negedge clk); seen = p1_req_ready; end
    @(posedge clk); #1;
    p1_req_valid = 1'b0; p1_src1 = 32'hFFFF_FFFF;
    p0_req_valid = 1'b1; p0_src1 = 32'd2; p0_src2 = 32'd3; p0_resp_ready = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin @(negedge clk); seen = p1_resp_valid; end
    checks++; if (!seen) begin failures++; $display("FAIL hold_resp_timeout got=0 exp=1"); end
    for (int h = 0; h < 5; h++) begin
      if (h > 0) @(negedge clk);
      checks++; if (p1_resp_valid !== 1'b1 || p1_resp_data !== 64'h1_0000 || p0_resp_valid !== 1'b0) begin
        failures++; $display("FAIL hold_resp_%0d got v=%b d=%h p0v=%b exp v=1 d=10000 p0v=0", h, p1_resp_valid, p1_resp_data, p0_resp_valid); end
      checks++; if (p0_req_ready !== 1'b0 || mul_en !== 1'b0) begin
        failures++; $display("FAIL hold_quiet_%0d got p0_ready=%b mul_en=%b exp 0 0", h, p0_req_ready, mul_en); end
    end
    @(posedge clk); #1;
    p1_resp_ready = 1'b1;
    @(negedge clk);
    checks++; if (p1_resp_valid !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL hold_handshake got v=%b busy=%b exp 1 1", p1_resp_valid, busy); end
    @(posedge clk); #1;
    p1_resp_ready = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || p0_req_ready !== 1'b1 || p1_resp_valid !== 1'b0) begin
      failures++; $display("FAIL hold_idle_after got busy=%b p0_ready=%b p1v=%b exp 0 1 0", busy, p0_req_ready, p1_resp_valid); end
    @(posedge clk); #1;
    p0_req_valid = 1'b0; p0_resp_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin @(negedge clk); seen = p0_resp_valid; end
    checks++; if (!seen || p0_resp_data !== 64'd6) begin
      failures++; $display("FAIL hold_followup got seen=%b d=%h exp seen=1 d=6", seen, p0_resp_data); end
    @(posedge clk); #1;
    p0_resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit seen, stray;
    logic [63:0] d; int lat, ef, ec; bit wp;
    seen = 1'b0; stray = 1'b0;
    @(posedge clk); #1;
    p0_req_valid = 1'b1; p0_src1 = 32'h0011_0022; p0_src2 = 32'h0033_0044; p0_resp_ready = 1'b1;
    for (int c = 0; c < 40 && !seen; c++) begin @(negedge clk); seen = p0_req_ready; end
    @(posedge clk); #1;
    p0_req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    checks++; if (mul_en !== 1'b1 || mul_a !== 16'h0022 || mul_b !== 16'h0033) begin
      failures++; $display("FAIL midreset_k2_issue got en=%b a=%h b=%h exp en=1 a=0022 b=0033", mul_en, mul_a, mul_b); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || p0_resp_valid !== 1'b0 || mul_en !== 1'b0) begin
      failures++; $display("FAIL midreset_abort got busy=%b v=%b en=%b exp 0 0 0", busy, p0_resp_valid, mul_en); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (p0_resp_valid || p1_resp_valid || busy) stray = 1'b1;
    end
    checks++; if (stray !== 1'b0) begin failures++; $display("FAIL midreset_stray got=1 exp=0"); end
    p0_resp_ready = 1'b0;
    run_txn(1'b0, 32'd7, 32'd9, d, lat, ef, ec, wp);
    $display("post-reset txn data=%h lat=%0d", d, lat);
    checks++; if (d !== 64'd63 || lat !== 6) begin
      failures++; $display("FAIL midreset_followup got d=%h lat=%0d exp d=3f lat=6", d, lat); end
  endtask

  task automatic test_lat3();
    bit seen;
    int lat;
    seen = 1'b0; lat = -1;
    @(posedge clk); #1;
    d3_p0_req_valid = 1'b1; d3_p0_src1 = 32'h8000_0000; d3_p0_src2 = 32'd2; d3_p0_resp_ready = 1'b1;
    for (int c = 0; c < 40 && !seen; c++) begin @(negedge clk); seen = d3_p0_req_ready; end
    @(posedge clk); #1;
    d3_p0_req_valid = 1'b0; d3_p0_src1 = 32'h1111_1111; d3_p0_src2 = 32'h2222_2222;
    if (seen) begin
      for (int c = 1; c <= 40; c++) begin
        @(negedge clk);
        if (d3_p0_resp_valid) begin lat = c; break; end
      end
    end
    $display("lat3 txn data=%h lat=%0d", d3_p0_resp_data, lat);
    checks++; if (lat !== 8) begin failures++; $display("FAIL lat3_latency got=%0d exp=8", lat); end
    checks++; if (d3_p0_resp_data !== 64'h0000_0001_0000_0000) begin
      failures++; $display("FAIL lat3_data got=%h exp=0000000100000000", d3_p0_resp_data); end
    @(posedge clk); #1;
    d3_p0_resp_ready = 1'b0;
    @(negedge clk);
    checks++; if (d3_busy !== 1'b0) begin failures++; $display("FAIL lat3_idle got=%b exp=0", d3_busy); end
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1;
    p0_req_valid = 1'b0; p0_src1 = '0; p0_src2 = '0; p0_resp_ready = 1'b0;
    p1_req_valid = 1'b0; p1_src1 = '0; p1_src2 = '0; p1_resp_ready = 1'b0;
    d3_p0_req_valid = 1'b0; d3_p0_src1 = '0; d3_p0_src2 = '0; d3_p0_resp_ready = 1'b0;
    d3_p1_req_valid = 1'b0; d3_p1_src1 = '0; d3_p1_src2 = '0; d3_p1_resp_ready = 1'b0;
    test_reset();
    test_basic();
    test_edges();
    test_round_robin();
    test_resp_hold();
    test_reset_mid();
    test_lat3();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
